// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

  localparam int ITERS_DEFAULT = 32;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between execute-stage control and the mul/div unit.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring compare-subtract divide.
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    // Partial remainder shifted left with the next dividend bit brought in.
    trial = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = trial[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      if (trial >= {1'b0, opnd_i}) acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
      else                         acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also services MTHI/MTLO.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input logic             clk,
  input logic             reset,
  mips_cpu_muldiv_if.slave bus
);
  localparam int CW = $clog2(ITERS) + 1;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic               is_div_q, neg_q, neg_rem_q, div_zero_q, done_q;

  logic               a_neg, b_neg, op_is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    a_neg     = is_signed_op(bus.op) & bus.a[WIDTH-1];
    b_neg     = is_signed_op(bus.op) & bus.b[WIDTH-1];
    // Unsigned negation keeps the magnitude of the most negative value intact.
    a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
    op_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                // Multiply seeds the accumulator with the multiplier, divide with the dividend.
                acc_q      <= {{WIDTH{1'b0}}, (op_is_div ? a_mag : b_mag)};
                opnd_q     <= op_is_div ? b_mag : a_mag;
                is_div_q   <= op_is_div;
                neg_q      <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (bus.b == '0);
                cnt_q      <= '0;
                state_q    <= ST_CALC;
              end
              OP_MTHI: begin
                hi_q   <= bus.a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITERS - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div_q) begin
            lo_q <= div_zero_q ? {WIDTH{1'b1}} : quot_fix;
            hi_q <= rem_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench: cycle-level arithmetic model compared every cycle plus literal expectations.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  localparam int LAT = ITERS_DEFAULT + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

  mips_cpu_muldiv #(.WIDTH(32), .ITERS(ITERS_DEFAULT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of an op: {hi, lo}.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] qx, qy;
    logic [63:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    qx = x;
    qy = y;
    r = '0;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(qx % qy), 32'(qx / qy)};
      end
      3'd3: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_cnt;
  logic        m_done;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_cnt <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
      end else if (bus.start) begin
        if (bus.op <= 3'd3) begin
          {p_hi, p_lo} <= model_result(bus.op, bus.a, bus.b);
          m_cnt <= LAT;
        end else if (bus.op == 3'd4) begin
          m_hi <= bus.a; m_done <= 1'b1;
        end else if (bus.op == 3'd5) begin
          m_lo <= bus.a; m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_cnt != 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input bit same_cycle, input int intr_at);
    int n;
    if (!same_cycle) @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(negedge clk);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (n == intr_at) begin
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0; bus.op = 3'($urandom_range(0, 7)); bus.a = $urandom; bus.b = $urandom;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({nm, " latency"}, 32'(n), 32'(lat));
    check({nm, " hi"}, bus.hi, eh);
    check({nm, " lo"}, bus.lo, el);
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", nm, o, av, bv, bus.hi, bus.lo, n);
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    bit seen;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);

    run_op("MTHI", 3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0, 0, 1'b0, -1);
    run_op("MTLO", 3'd5, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b1, -1);
    run_op("MULTU", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT, 1'b0, -1);
    run_op("MULT", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT, 1'b0, -1);
    run_op("DIV", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT, 1'b0, -1);
    run_op("DIVU", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, LAT, 1'b0, -1);
    run_op("DIV ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, LAT, 1'b0, -1);
    run_op("DIVU by0", 3'd3, 32'h0000_0055, 32'd0, 32'h0000_0055, 32'hFFFF_FFFF, LAT, 1'b0, -1);
    run_op("DIV by0", 3'd2, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, LAT, 1'b0, -1);
    run_op("MULTU intr", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, LAT, 1'b0, 10);
    run_op("MULT b2b", 3'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000, LAT, 1'b1, -1);

    for (int i = 0; i < 6; i++) begin
      ro = 3'(i % 4);
      ra = $urandom;
      rb = (i == 5) ? 32'd3 : $urandom;
      r = model_result(ro, ra, rb);
      run_op("RAND", ro, ra, rb, r[63:32], r[31:0], LAT, 1'b0, -1);
    end

    // Reserved op must produce nothing.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'h1111_1111; bus.b = 32'd5;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("reserved op ignored", 32'(seen), 32'd0);
    $display("RSVD op=7 -> hi=%h lo=%h", bus.hi, bus.lo);

    // Reset mid-divide aborts.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort no done", 32'(seen), 32'd0);
    $display("ABORT DIV reset at cycle 15 -> hi=%h lo=%h", bus.hi, bus.lo);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
